stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/stopwatch_ctrl_tick_gen.sv | 50 +++++
 rtl/stopwatch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state encoding,
// counter limits and the modulo-(max+1) increment helper.
package stopwatch_pkg;

  localparam int DIV_W   = 32;
  localparam int CNT_MAX = 59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_e;

  function automatic logic [5:0] cnt_next(input logic [5:0] v, input logic [5:0] max_v);
    return (v == max_v) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Programmable prescaler: pulses tick once every num enabled cycles
// (every enabled cycle for num of 0 or 1); clr zeroes the fraction.
module tick_gen #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] num,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] ZERO = {DIV_W{1'b0}};

  logic [DIV_W-1:0] pcnt_q;
  logic [DIV_W-1:0] pcnt_d;
  logic [DIV_W-1:0] term_s;

  // Terminal compare; >= lets a shrinking num wrap on the next enabled cycle.
  always_comb begin
    term_s = (num <= ONE) ? ZERO : num - ONE;
    tick   = en & (pcnt_q >= term_s);
  end

  // Prescaler next state: clear, wrap on tick, count while enabled, else hold.
  always_comb begin
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = ZERO;
    end else if (tick) begin
      pcnt_d = ZERO;
    end else if (en) begin
      pcnt_d = pcnt_q + ONE;
    end else begin
      pcnt_d = pcnt_q;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q <= ZERO;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/pause/lap/clear FSM sequencing the prescaler,
// cascaded seconds/minutes counters and the lap-frozen display registers.
module stopwatch_ctrl #(
  parameter int DIV_W   = stopwatch_pkg::DIV_W,
  parameter int CNT_MAX = stopwatch_pkg::CNT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] num,
  input  logic             btn_start,
  input  logic             btn_lap,
  input  logic             btn_clear,
  output logic [5:0]       sec,
  output logic [5:0]       min,
  output logic             tick,
  output logic             running,
  output logic             lap_hold,
  output logic             wrap
);

  import stopwatch_pkg::*;

  localparam logic [5:0] MAX_S = 6'(CNT_MAX);

  state_e     state_q, state_d;
  logic       clr_s, snap_en_s, en_s, tick_s;
  logic [5:0] sec_q, sec_d, min_q, min_d;
  logic [5:0] snap_sec_q, snap_sec_d, snap_min_q, snap_min_d;
  logic [5:0] disp_sec_q, disp_sec_d, disp_min_q, disp_min_d;
  logic       running_q, lap_hold_q, wrap_q, wrap_d;

  assign en_s = (state_q == RUN) || (state_q == LAP);

  tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_s),
    .clr   (clr_s),
    .num   (num),
    .tick  (tick_s)
  );

  // Button FSM; clear outranks start, start outranks lap.
  always_comb begin
    state_d   = state_q;
    clr_s     = 1'b0;
    snap_en_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_clear) begin
          state_d = IDLE;
        end else if (btn_start) begin
          state_d = RUN;
          clr_s   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (btn_start) begin
          state_d = PAUSE;
        end else if (btn_lap) begin
          state_d   = LAP;
          snap_en_s = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      LAP: begin
        if (btn_start) begin
          state_d = PAUSE;
        end else if (btn_lap) begin
          state_d = RUN;
        end else begin
          state_d = LAP;
        end
      end
      PAUSE: begin
        if (btn_clear) begin
          state_d = IDLE;
          clr_s   = 1'b1;
        end else if (btn_start) begin
          state_d = RUN;
        end else begin
          state_d = PAUSE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Live counters, snapshot and the display selection for the next cycle.
  always_comb begin
    sec_d      = sec_q;
    min_d      = min_q;
    snap_sec_d = snap_sec_q;
    snap_min_d = snap_min_q;
    wrap_d     = tick_s & (sec_q == MAX_S) & (min_q == MAX_S);
    if (clr_s) begin
      sec_d = 6'd0;
      min_d = 6'd0;
    end else if (tick_s) begin
      sec_d = cnt_next(sec_q, MAX_S);
      min_d = (sec_q == MAX_S) ? cnt_next(min_q, MAX_S) : min_q;
    end else begin
      sec_d = sec_q;
      min_d = min_q;
    end
    if (clr_s) begin
      snap_sec_d = 6'd0;
      snap_min_d = 6'd0;
    end else if (snap_en_s) begin
      snap_sec_d = sec_q;
      snap_min_d = min_q;
    end else begin
      snap_sec_d = snap_sec_q;
      snap_min_d = snap_min_q;
    end
    if (state_d == LAP) begin
      disp_sec_d = snap_sec_d;
      disp_min_d = snap_min_d;
    end else begin
      disp_sec_d = sec_d;
      disp_min_d = min_d;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      snap_sec_q <= 6'd0;
      snap_min_q <= 6'd0;
      disp_sec_q <= 6'd0;
      disp_min_q <= 6'd0;
      running_q  <= 1'b0;
      lap_hold_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      snap_sec_q <= snap_sec_d;
      snap_min_q <= snap_min_d;
      disp_sec_q <= disp_sec_d;
      disp_min_q <= disp_min_d;
      running_q  <= (state_d == RUN) || (state_d == LAP);
      lap_hold_q <= (state_d == LAP);
      wrap_q     <= wrap_d;
    end
  end

  assign sec      = disp_sec_q;
  assign min      = disp_min_q;
  assign tick     = tick_s;
  assign running  = running_q;
  assign lap_hold = lap_hold_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: count, pause/resume, lap, clear rules,
// mid-count reset, num change and full 59:59 rollover.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] num;
  logic        btn_start, btn_lap, btn_clear;
  logic [5:0]  sec, min;
  logic        tick, running, lap_hold, wrap;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_cnt;

  stopwatch_ctrl #(.DIV_W(32), .CNT_MAX(59)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .num       (num),
    .btn_start (btn_start),
    .btn_lap   (btn_lap),
    .btn_clear (btn_clear),
    .sec       (sec),
    .min       (min),
    .tick      (tick),
    .running   (running),
    .lap_hold  (lap_hold),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic s, input logic l, input logic c);
    btn_start = s;
    btn_lap   = l;
    btn_clear = c;
    @(posedge clk);
    #1;
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; num = 32'd4;
    btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    step(2);
    rst_n = 1'b1;
    check_eq("rst_sec", 32'(sec), 32'd0);
    check_eq("rst_min", 32'(min), 32'd0);
    check_eq("rst_running", 32'(running), 32'd0);
    check_eq("rst_lap_hold", 32'(lap_hold), 32'd0);
    check_eq("rst_wrap", 32'(wrap), 32'd0);
    check_eq("rst_tick", 32'(tick), 32'd0);

    // basic count, num=4
    press(1'b1, 1'b0, 1'b0);
    check_eq("start_running", 32'(running), 32'd1);
    check_eq("start_tick", 32'(tick), 32'd0);
    step(2);
    check_eq("pre_tick", 32'(tick), 32'd0);
    step(1);
    check_eq("first_tick", 32'(tick), 32'd1);
    check_eq("first_tick_sec", 32'(sec), 32'd0);
    step(1);
    check_eq("sec_after_tick", 32'(sec), 32'd1);
    check_eq("tick_low", 32'(tick), 32'd0);
    step(8);
    check_eq("sec_12cyc", 32'(sec), 32'd3);

    // pause with two counts of fraction, hold, resume
    step(1);
    press(1'b1, 1'b0, 1'b0);
    check_eq("pause_running", 32'(running), 32'd0);
    tick_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (tick) tick_cnt++;
    end
    check_eq("pause_no_tick", 32'(tick_cnt), 32'd0);
    check_eq("pause_sec", 32'(sec), 32'd3);
    press(1'b1, 1'b0, 1'b0);
    check_eq("resume_tick0", 32'(tick), 32'd0);
    step(1);
    check_eq("resume_tick1", 32'(tick), 32'd1);
    step(1);
    check_eq("resume_sec", 32'(sec), 32'd4);

    // back to IDLE through PAUSE
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    check_eq("clr_sec", 32'(sec), 32'd0);
    check_eq("clr_min", 32'(min), 32'd0);
    check_eq("clr_running", 32'(running), 32'd0);
    check_eq("clr_tick", 32'(tick), 32'd0);

    // lap freeze, num=2
    num = 32'd2;
    press(1'b1, 1'b0, 1'b0);
    step(10);
    check_eq("lap_pre_sec", 32'(sec), 32'd5);
    press(1'b0, 1'b1, 1'b0);
    check_eq("lap_hold_on", 32'(lap_hold), 32'd1);
    check_eq("lap_running", 32'(running), 32'd1);
    check_eq("lap_sec", 32'(sec), 32'd5);
    step(9);
    check_eq("lap_frozen_sec", 32'(sec), 32'd5);
    check_eq("lap_frozen_hold", 32'(lap_hold), 32'd1);
    press(1'b0, 1'b1, 1'b0);
    check_eq("lap_release_sec", 32'(sec), 32'd10);
    check_eq("lap_release_hold", 32'(lap_hold), 32'd0);

    // clear ignored in RUN (tick lands on this edge)
    press(1'b0, 1'b0, 1'b1);
    check_eq("run_clr_sec", 32'(sec), 32'd11);
    check_eq("run_clr_running", 32'(running), 32'd1);
    // start+lap in RUN -> PAUSE, no lap
    press(1'b1, 1'b1, 1'b0);
    check_eq("sl_running", 32'(running), 32'd0);
    check_eq("sl_lap_hold", 32'(lap_hold), 32'd0);
    check_eq("sl_sec", 32'(sec), 32'd11);
    // start+clear in PAUSE -> IDLE
    press(1'b1, 1'b0, 1'b1);
    check_eq("sc_sec", 32'(sec), 32'd0);
    check_eq("sc_running", 32'(running), 32'd0);
    step(3);
    check_eq("idle_sec", 32'(sec), 32'd0);
    check_eq("idle_tick", 32'(tick), 32'd0);

    // mid-count reset at sec=7
    press(1'b1, 1'b0, 1'b0);
    step(14);
    check_eq("mid_pre_sec", 32'(sec), 32'd7);
    rst_n = 1'b0;
    step(1);
    check_eq("mid_rst_sec", 32'(sec), 32'd0);
    check_eq("mid_rst_running", 32'(running), 32'd0);
    check_eq("mid_rst_tick", 32'(tick), 32'd0);
    rst_n = 1'b1;
    step(4);
    check_eq("post_rst_sec", 32'(sec), 32'd0);
    check_eq("post_rst_running", 32'(running), 32'd0);

    // num 10 -> 3 with pcnt=6
    num = 32'd10;
    press(1'b1, 1'b0, 1'b0);
    step(6);
    check_eq("num10_tick", 32'(tick), 32'd0);
    num = 32'd3;
    #1;
    check_eq("num3_tick", 32'(tick), 32'd1);
    step(1);
    check_eq("num3_sec", 32'(sec), 32'd1);
    check_eq("num3_tick_low", 32'(tick), 32'd0);
    step(2);
    check_eq("num3_next_tick", 32'(tick), 32'd1);

    // full rollover at num=1
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    num = 32'd1;
    press(1'b1, 1'b0, 1'b0);
    check_eq("num1_tick", 32'(tick), 32'd1);
    step(3599);
    check_eq("roll_min59", 32'(min), 32'd59);
    check_eq("roll_sec59", 32'(sec), 32'd59);
    check_eq("roll_wrap0", 32'(wrap), 32'd0);
    step(1);
    check_eq("roll_min0", 32'(min), 32'd0);
    check_eq("roll_sec0", 32'(sec), 32'd0);
    check_eq("roll_wrap1", 32'(wrap), 32'd1);
    step(1);
    check_eq("roll_wrap_end", 32'(wrap), 32'd0);
    check_eq("roll_sec1", 32'(sec), 32'd1);
    num = 32'd0;
    #1;
    check_eq("num0_tick", 32'(tick), 32'd1);
    press(1'b1, 1'b0, 1'b0);
    check_eq("paused_tick", 32'(tick), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
